// File: rtl/deser_queue_param.sv
// Serial-to-parallel front end feeding a DEPTH-entry word queue.
// Strobes are edge-detected in the clock domain; the queue tracks overflow and underflow with sticky flags.
module deser_queue_param #(
  parameter int WORD_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int LEN_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  data_in,
  input  logic                  write_in,
  output logic                  status_out,
  input  logic                  dequeue_in,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic [LEN_WIDTH-1:0]  len_out,
  output logic                  overflow_out,
  output logic                  underflow_out,
  input  logic                  clear_in
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(WORD_WIDTH);

  typedef struct packed {
    logic push;
    logic pop;
    logic drop;
    logic under;
  } q_ctl_t;

  logic [DEPTH-1:0][WORD_WIDTH-1:0] mem;
  logic [WORD_WIDTH-1:0]            shreg, shreg_next;
  logic [CNT_W-1:0]                 cnt;
  logic [PTR_W-1:0]                 wptr, rptr;
  logic                             write_prev, dequeue_prev;
  logic                             wr_edge, pop_edge, word_done, empty, full;
  logic [LEN_WIDTH-1:0]             next_len;
  q_ctl_t                           ctl;

  // Non-power-of-two depths need an explicit wrap point.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  generate
    if (MSB_FIRST) begin : g_msb
      assign shreg_next = {shreg[WORD_WIDTH-2:0], data_in};
    end else begin : g_lsb
      assign shreg_next = {data_in, shreg[WORD_WIDTH-1:1]};
    end
  endgenerate

  assign wr_edge   = write_in & ~write_prev;
  assign pop_edge  = dequeue_in & ~dequeue_prev;
  assign word_done = wr_edge && (cnt == CNT_W'(WORD_WIDTH - 1));
  assign empty     = (len_out == '0);
  assign full      = (len_out == LEN_WIDTH'(DEPTH));

  // A pop on an empty queue is an underflow even if a word lands on the same edge.
  always_comb begin
    ctl       = '0;
    ctl.pop   = pop_edge && !empty && !clear_in;
    ctl.under = pop_edge && empty && !clear_in;
    ctl.push  = word_done && (!full || ctl.pop) && !clear_in;
    ctl.drop  = word_done && full && !ctl.pop && !clear_in;
    next_len  = len_out;
    if (clear_in) begin
      next_len = '0;
    end else begin
      unique case ({ctl.push, ctl.pop})
        2'b10:   next_len = len_out + LEN_WIDTH'(1);
        2'b01:   next_len = len_out - LEN_WIDTH'(1);
        default: next_len = len_out;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (ctl.push) mem[wptr] <= shreg_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      write_prev     <= 1'b0;
      dequeue_prev   <= 1'b0;
      shreg          <= '0;
      cnt            <= '0;
      wptr           <= '0;
      rptr           <= '0;
      len_out        <= '0;
      status_out     <= 1'b0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      overflow_out   <= 1'b0;
      underflow_out  <= 1'b0;
    end else begin
      write_prev     <= write_in;
      dequeue_prev   <= dequeue_in;
      len_out        <= next_len;
      status_out     <= (next_len < LEN_WIDTH'(DEPTH));
      data_valid_out <= ctl.pop;
      if (clear_in) begin
        shreg         <= '0;
        cnt           <= '0;
        wptr          <= '0;
        rptr          <= '0;
        overflow_out  <= 1'b0;
        underflow_out <= 1'b0;
      end else begin
        if (wr_edge) begin
          shreg <= shreg_next;
          cnt   <= word_done ? '0 : cnt + CNT_W'(1);
        end
        if (ctl.push) wptr <= ptr_inc(wptr);
        if (ctl.pop) begin
          data_out <= mem[rptr];
          rptr     <= ptr_inc(rptr);
        end
        if (ctl.drop)  overflow_out  <= 1'b1;
        if (ctl.under) underflow_out <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_deser_queue_param.sv
// Bench for deser_queue_param: five parameterisations share one stimulus stream;
// each scenario checks the instance it targets against a queue of expected words.
module tb_deser_queue_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, din, wr, deq, clr;

  // 0: W8 D8 MSB, 1: W8 D4 MSB, 2: W8 D8 LSB, 3: W12 D8 MSB, 4: W8 D3 MSB
  logic        st0, st1, st2, st3, st4;
  logic [7:0]  do0, do1, do2, do4;
  logic [11:0] do3;
  logic        dv0, dv1, dv2, dv3, dv4;
  logic [3:0]  ln0, ln2, ln3;
  logic [2:0]  ln1;
  logic [1:0]  ln4;
  logic        ov0, ov1, ov2, ov3, ov4;
  logic        un0, un1, un2, un3, un4;

  deser_queue_param u_def (.clock(clk), .reset(reset), .data_in(din), .write_in(wr), .status_out(st0),
    .dequeue_in(deq), .data_out(do0), .data_valid_out(dv0), .len_out(ln0), .overflow_out(ov0),
    .underflow_out(un0), .clear_in(clr));
  deser_queue_param #(.DEPTH(4)) u_d4 (.clock(clk), .reset(reset), .data_in(din), .write_in(wr),
    .status_out(st1), .dequeue_in(deq), .data_out(do1), .data_valid_out(dv1), .len_out(ln1),
    .overflow_out(ov1), .underflow_out(un1), .clear_in(clr));
  deser_queue_param #(.MSB_FIRST(1'b0)) u_lsb (.clock(clk), .reset(reset), .data_in(din), .write_in(wr),
    .status_out(st2), .dequeue_in(deq), .data_out(do2), .data_valid_out(dv2), .len_out(ln2),
    .overflow_out(ov2), .underflow_out(un2), .clear_in(clr));
  deser_queue_param #(.WORD_WIDTH(12)) u_w12 (.clock(clk), .reset(reset), .data_in(din), .write_in(wr),
    .status_out(st3), .dequeue_in(deq), .data_out(do3), .data_valid_out(dv3), .len_out(ln3),
    .overflow_out(ov3), .underflow_out(un3), .clear_in(clr));
  deser_queue_param #(.DEPTH(3)) u_d3 (.clock(clk), .reset(reset), .data_in(din), .write_in(wr),
    .status_out(st4), .dequeue_in(deq), .data_out(do4), .data_valid_out(dv4), .len_out(ln4),
    .overflow_out(ov4), .underflow_out(un4), .clear_in(clr));

  int tests = 0;
  int fails = 0;
  logic [11:0] sb[$];

  function automatic logic [11:0] get_dout(input int i);
    case (i)
      0: return {4'h0, do0};
      1: return {4'h0, do1};
      2: return {4'h0, do2};
      3: return do3;
      default: return {4'h0, do4};
    endcase
  endfunction

  function automatic logic get_dv(input int i);
    case (i)
      0: return dv0;
      1: return dv1;
      2: return dv2;
      3: return dv3;
      default: return dv4;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int hold);
    din = b;
    wr  = 1'b1;
    repeat (hold) tick();
    wr  = 1'b0;
    repeat (hold) tick();
  endtask

  // Serialises MSB first; bit order at the receiver is the DUT's business.
  task automatic send_word(input logic [11:0] w, input int width, input int hold);
    for (int i = width - 1; i >= 0; i--) send_bit(w[i], hold);
  endtask

  task automatic pop_strobe(input int idx, output logic dv_seen, output logic [11:0] d_seen,
                            output logic dv_next);
    deq = 1'b1;
    tick();
    dv_seen = get_dv(idx);
    d_seen  = get_dout(idx);
    tick();
    dv_next = get_dv(idx);
    deq = 1'b0;
    tick();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1; din = 1'b0; wr = 1'b0; deq = 1'b0; clr = 1'b0;
    repeat (cycles) tick();
    reset = 1'b0;
    tick();
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; din = 1'b0; wr = 1'b0; deq = 1'b0; clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({st0, do0, dv0, ln0, ov0, un0} !== 16'h0) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: got %h want 0", i, {st0, do0, dv0, ln0, ov0, un0});
      end
    end
    reset = 1'b0;
    tick();
    tests++;
    if (st0 !== 1'b1 || ln0 !== 4'd0) begin
      fails++;
      $display("FAIL reset_release: status=%b len=%0d want status=1 len=0", st0, ln0);
    end
  endtask

  task automatic test_basic();
    logic dvs, dvn;
    logic [11:0] d, exp;
    do_reset(2);
    for (int i = 0; i < 7; i++) send_bit(i == 0, 10);
    tests++;
    if (ln0 !== 4'd0) begin
      fails++;
      $display("FAIL basic_partial_len: got %0d want 0", ln0);
    end
    send_bit(1'b0, 10);
    sb.push_back(12'h080);
    tests++;
    if (ln0 !== 4'd1) begin
      fails++;
      $display("FAIL basic_len: got %0d want 1", ln0);
    end
    pop_strobe(0, dvs, d, dvn);
    exp = sb.pop_front();
    tests++;
    if (dvs !== 1'b1 || d !== exp || dvn !== 1'b0 || ln0 !== 4'd0) begin
      fails++;
      $display("FAIL basic_pop: dv=%b data=%h dv_next=%b len=%0d want 1 %h 0 0", dvs, d, dvn, ln0, exp);
    end
  endtask

  task automatic test_overflow();
    logic dvs, dvn;
    logic [11:0] d, exp;
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      send_word(12'h080 + 12'(i), 8, 2);
      sb.push_back(12'h080 + 12'(i));
    end
    tests++;
    if (st1 !== 1'b0 || ln1 !== 3'd4) begin
      fails++;
      $display("FAIL ovf_full: status=%b len=%0d want 0 4", st1, ln1);
    end
    send_word(12'h084, 8, 2);
    tests++;
    if (ov1 !== 1'b1 || ln1 !== 3'd4) begin
      fails++;
      $display("FAIL ovf_drop: overflow=%b len=%0d want 1 4", ov1, ln1);
    end
    for (int i = 0; i < 4; i++) begin
      pop_strobe(1, dvs, d, dvn);
      exp = (sb.size() > 0) ? sb.pop_front() : 12'hFFF;
      tests++;
      if (dvs !== 1'b1 || d !== exp || dvn !== 1'b0) begin
        fails++;
        $display("FAIL ovf_pop%0d: dv=%b data=%h dv_next=%b want 1 %h 0", i, dvs, d, dvn, exp);
      end
    end
    tests++;
    if (ln1 !== 3'd0 || st1 !== 1'b1) begin
      fails++;
      $display("FAIL ovf_drained: len=%0d status=%b want 0 1", ln1, st1);
    end
    pop_strobe(1, dvs, d, dvn);
    tests++;
    if (dvs !== 1'b0 || un1 !== 1'b1 || d !== 12'h083) begin
      fails++;
      $display("FAIL underflow: dv=%b underflow=%b data=%h want 0 1 083", dvs, un1, d);
    end
  endtask

  task automatic test_bit_order();
    logic dvs, dvn;
    logic [11:0] d;
    do_reset(2);
    send_word(12'h080, 8, 2);
    pop_strobe(2, dvs, d, dvn);
    tests++;
    if (dvs !== 1'b1 || d !== 12'h001) begin
      fails++;
      $display("FAIL lsb_first: dv=%b data=%h want 1 001", dvs, d);
    end
    do_reset(2);
    send_word(12'hA5C, 12, 2);
    pop_strobe(3, dvs, d, dvn);
    tests++;
    if (dvs !== 1'b1 || d !== 12'hA5C) begin
      fails++;
      $display("FAIL width12: dv=%b data=%h want 1 a5c", dvs, d);
    end
  endtask

  task automatic test_full_simul();
    logic dvs, dvn;
    logic [11:0] d, exp, w;
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      send_word(12'h080 + 12'(i), 8, 2);
      sb.push_back(12'h080 + 12'(i));
    end
    w = 12'h0C5;
    for (int i = 7; i > 0; i--) send_bit(w[i], 2);
    sb.push_back(w);
    din = w[0]; wr = 1'b1; deq = 1'b1;
    tick();
    exp = sb.pop_front();
    tests++;
    if (dv1 !== 1'b1 || do1 !== exp[7:0] || ln1 !== 3'd4 || ov1 !== 1'b0) begin
      fails++;
      $display("FAIL full_simul: dv=%b data=%h len=%0d ovf=%b want 1 %h 4 0", dv1, do1, ln1, ov1, exp);
    end
    tick();
    wr = 1'b0; deq = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      pop_strobe(1, dvs, d, dvn);
      exp = (sb.size() > 0) ? sb.pop_front() : 12'hFFF;
      tests++;
      if (dvs !== 1'b1 || d !== exp) begin
        fails++;
        $display("FAIL full_simul_drain%0d: dv=%b data=%h want 1 %h", i, dvs, d, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic dvs, dvn;
    logic [11:0] d, exp;
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      send_word(12'h010 + 12'(i * 7), 8, 1);
      sb.push_back(12'h010 + 12'(i * 7));
      if (i >= 1 || i == 9) begin
        pop_strobe(4, dvs, d, dvn);
        exp = sb.pop_front();
        tests++;
        if (dvs !== 1'b1 || d !== exp) begin
          fails++;
          $display("FAIL wrap_pop%0d: dv=%b data=%h want 1 %h", i, dvs, d, exp);
        end
      end
    end
    pop_strobe(4, dvs, d, dvn);
    exp = (sb.size() > 0) ? sb.pop_front() : 12'hFFF;
    tests++;
    if (dvs !== 1'b1 || d !== exp || ov4 !== 1'b0 || un4 !== 1'b0 || ln4 !== 2'd0) begin
      fails++;
      $display("FAIL wrap_last: dv=%b data=%h ovf=%b unf=%b len=%0d want 1 %h 0 0 0", dvs, d, ov4, un4, ln4, exp);
    end
  endtask

  task automatic test_clear_and_reset(input bit use_reset);
    logic dvs, dvn;
    logic [11:0] d;
    do_reset(2);
    pop_strobe(0, dvs, d, dvn);
    send_word(12'h011, 8, 2);
    send_word(12'h022, 8, 2);
    send_bit(1'b1, 2); send_bit(1'b1, 2); send_bit(1'b1, 2);
    tests++;
    if (un0 !== 1'b1 || ln0 !== 4'd2) begin
      fails++;
      $display("FAIL flush_setup: underflow=%b len=%0d want 1 2", un0, ln0);
    end
    if (use_reset) reset = 1'b1;
    else clr = 1'b1;
    tick();
    reset = 1'b0; clr = 1'b0;
    tick();
    tests++;
    if (ln0 !== 4'd0 || ov0 !== 1'b0 || un0 !== 1'b0 || st0 !== 1'b1) begin
      fails++;
      $display("FAIL flush_state(%0d): len=%0d ovf=%b unf=%b status=%b want 0 0 0 1", use_reset, ln0, ov0, un0, st0);
    end
    send_word(12'h080, 8, 2);
    pop_strobe(0, dvs, d, dvn);
    tests++;
    if (dvs !== 1'b1 || d !== 12'h080 || ln0 !== 4'd0) begin
      fails++;
      $display("FAIL flush_fresh(%0d): dv=%b data=%h len=%0d want 1 080 0", use_reset, dvs, d, ln0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_bit_order();
    test_full_simul();
    test_wrap();
    test_clear_and_reset(1'b0);
    test_clear_and_reset(1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
